// File: rtl/vga_pixel_prefetch_if.sv
// Read-request / read-response bus between the pixel prefetcher and frame memory.
// Responses come back in request order, one word per mem_rvalid.
interface vga_pixel_prefetch_if;
   logic        mem_rd;
   logic [31:0] mem_addr;
   logic        mem_ready;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   modport master (output mem_rd, mem_addr, input mem_ready, mem_rvalid, mem_rdata);
   modport slave  (input mem_rd, mem_addr, output mem_ready, mem_rvalid, mem_rdata);
endinterface

// File: rtl/vga_pixel_prefetch.sv
// Prefetches a frame of packed 8-bit pixels from memory into a small FIFO and
// hands them out one byte per pix_req, with credit-based request throttling.
module vga_pixel_prefetch #(
   parameter int FRAME_WORDS = 76800,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 frame_start,
   input  logic [31:0]          base_addr,
   input  logic                 pix_req,
   output logic [7:0]           video_data,
   output logic                 underflow,
   vga_pixel_prefetch_if.master mem
);
   localparam int WI_W = $clog2(FRAME_WORDS + 1);
   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int CW   = AW + 1;

   typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;
   state_t state, state_nxt;

   logic [WI_W-1:0]                word_index;
   logic [31:0]                    base_q;
   logic [CW-1:0]                  fifo_count, outstanding, discard;
   logic [AW-1:0]                  wr_ptr, rd_ptr;
   logic [FIFO_DEPTH-1:0][31:0]    fifo_mem;
   logic [31:0]                    head;
   logic [1:0]                     lane;
   logic [CW:0]                    in_use;
   logic                           accept, rsp, push, take, pop;

   // Discarded reads still hold a credit until their data comes back.
   assign in_use        = {1'b0, fifo_count} + {1'b0, outstanding};
   assign mem.mem_rd    = (state == FETCH) && !frame_start && (in_use < (CW+1)'(FIFO_DEPTH));
   assign mem.mem_addr  = base_q + (32'(word_index) << 2);
   assign accept        = mem.mem_rd && mem.mem_ready;
   assign rsp           = mem.mem_rvalid && (outstanding != '0);
   assign push          = rsp && !frame_start && (discard == '0);
   assign take          = pix_req && !frame_start && (fifo_count != '0);
   assign pop           = take && (lane == 2'd3);
   assign head          = fifo_mem[rd_ptr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         FETCH:   if (accept && word_index == WI_W'(FRAME_WORDS - 1)) state_nxt = DONE;
         IDLE:    state_nxt = IDLE;
         DONE:    state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
      if (frame_start) state_nxt = FETCH;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         base_q      <= '0;
         word_index  <= '0;
         outstanding <= '0;
         discard     <= '0;
      end else begin
         outstanding <= outstanding + CW'(accept) - CW'(rsp);
         if (frame_start) begin
            // Everything still in flight belongs to the old frame.
            base_q     <= base_addr;
            word_index <= '0;
            discard    <= outstanding - CW'(rsp);
         end else begin
            if (accept)                word_index <= word_index + WI_W'(1);
            if (rsp && discard != '0)  discard    <= discard - CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= mem.mem_rdata;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else if (frame_start) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         fifo_count <= fifo_count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         video_data <= 8'h00;
         underflow  <= 1'b0;
         lane       <= 2'd0;
      end else if (frame_start) begin
         video_data <= 8'h00;
         underflow  <= 1'b0;
         lane       <= 2'd0;
      end else if (take) begin
         video_data <= head[{lane, 3'b000} +: 8];
         lane       <= lane + 2'd1;
      end else if (pix_req) begin
         video_data <= 8'h00;
         underflow  <= 1'b1;
      end
   end
endmodule

// File: tb/tb_vga_pixel_prefetch.sv
// Bench for vga_pixel_prefetch: directed scenarios plus a randomized phase,
// checked against a frame-level model of the pixel stream and request rules.
module tb_vga_pixel_prefetch;
   logic        clk = 1'b0, reset = 1'b0, frame_start = 1'b0, pix_req = 1'b0;
   logic [31:0] base_addr = '0;
   logic [7:0]  vd0, vd1;
   logic        uf0, uf1;
   int          checks = 0, errors = 0, frame_id = 0;
   bit          hold = 0, rnd = 0, rdy_off = 0;
   logic [31:0] seed;

   vga_pixel_prefetch_if mif [2] ();

   always #5 clk = ~clk;

   vga_pixel_prefetch #(.FRAME_WORDS(76800), .FIFO_DEPTH(8)) dut0 (
      .clk(clk), .reset(reset), .frame_start(frame_start), .base_addr(base_addr),
      .pix_req(pix_req), .video_data(vd0), .underflow(uf0), .mem(mif[0]));
   vga_pixel_prefetch #(.FRAME_WORDS(4), .FIFO_DEPTH(8)) dut1 (
      .clk(clk), .reset(reset), .frame_start(frame_start), .base_addr(base_addr),
      .pix_req(pix_req), .video_data(vd1), .underflow(uf1), .mem(mif[1]));

   function automatic logic [31:0] word_at(input logic [31:0] a);
      if (a == 32'h1000) return 32'h44332211;
      return (a * 32'h9E3779B1) ^ seed;
   endfunction

   function automatic logic [31:0] byte_of(input logic [31:0] base, input int n);
      logic [31:0] w;
      w = word_at(base + 32'(4 * (n / 4)));
      return (w >> (8 * (n % 4))) & 32'hFF;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // In-order memory: fixed 2-cycle latency, optionally jittered and throttled.
   for (genvar g = 0; g < 2; g++) begin : g_mem
      logic [31:0] q_addr[$];
      int          q_due[$];
      int          q_tag[$];
      int          lc = 0, acc_cnt = 0, rv_tag = 0;

      always @(posedge clk) begin
         if (!reset) begin
            q_addr.delete(); q_due.delete(); q_tag.delete();
         end else if (mif[g].mem_rd === 1'b1 && mif[g].mem_ready === 1'b1) begin
            q_addr.push_back(mif[g].mem_addr);
            q_due.push_back(lc + 2 + (rnd ? int'($urandom_range(0, 2)) : 0));
            q_tag.push_back(frame_id);
            acc_cnt++;
         end
      end

      always @(negedge clk) begin
         #1;
         lc++;
         mif[g].mem_ready = !rdy_off && (!rnd || $urandom_range(0, 3) != 0);
         if (!reset) begin
            q_addr.delete(); q_due.delete(); q_tag.delete();
         end
         if (reset && !hold && q_addr.size() > 0 && q_due[0] <= lc) begin
            mif[g].mem_rvalid = 1'b1;
            mif[g].mem_rdata  = word_at(q_addr[0]);
            rv_tag            = q_tag[0];
            void'(q_addr.pop_front()); void'(q_due.pop_front()); void'(q_tag.pop_front());
         end else begin
            mif[g].mem_rvalid = 1'b0;
            mif[g].mem_rdata  = '0;
         end
      end
   end

   // Frame-level model of dut0: pixel n of a frame is byte n%4 of word n/4.
   logic [31:0] m_base = '0, last_addr0 = '0, prev_addr = '0, s_addr;
   int          m_acc = 0, m_cons = 0, m_ret = 0, m_out = 0, s_tag;
   logic [7:0]  m_vd = '0;
   logic        m_uf = 1'b0;
   bit          m_started = 0, prev_pend = 0, s_fs, s_pr, s_rv, s_rd, s_rdy;

   always @(posedge clk) begin
      s_fs = frame_start; s_pr = pix_req; s_rv = mif[0].mem_rvalid; s_tag = g_mem[0].rv_tag;
      s_rd = mif[0].mem_rd; s_rdy = mif[0].mem_ready; s_addr = mif[0].mem_addr;
      if (!reset) begin
         m_vd = '0; m_uf = 1'b0; m_acc = 0; m_cons = 0; m_ret = 0; m_out = 0;
         m_started = 0; prev_pend = 0;
      end else begin
         if (!m_started) chk("no_req_before_start", 32'(s_rd), 0);
         if (prev_pend)  chk("req_held_stable", 32'(s_fs || (s_rd && s_addr == prev_addr)), 1);
         if (s_fs)       chk("req_withdrawn_on_start", 32'(s_rd), 0);
         if (s_rd && s_rdy) begin
            chk("req_addr", s_addr, m_base + 32'(4 * m_acc));
            chk("req_credit", 32'((m_ret - m_cons / 4) + m_out < 8), 1);
            m_acc++; m_out++; last_addr0 = s_addr;
         end
         if (s_rv) m_out--;
         prev_pend = s_rd && !s_rdy;
         prev_addr = s_addr;
         if (s_fs) begin
            m_started = 1; m_base = base_addr; m_acc = 0; m_cons = 0; m_ret = 0;
            m_vd = '0; m_uf = 1'b0;
         end else begin
            if (s_pr) begin
               if (4 * m_ret > m_cons) begin
                  m_vd = 8'(byte_of(m_base, m_cons));
                  m_cons++;
               end else begin
                  m_vd = '0; m_uf = 1'b1;
               end
            end
            if (s_rv && s_tag == frame_id) m_ret++;
         end
      end
      #1;
      chk("video_data", 32'(vd0), 32'(m_vd));
      chk("underflow", 32'(uf0), 32'(m_uf));
   end

   task automatic start(input logic [31:0] a);
      @(negedge clk);
      frame_start = 1'b1; base_addr = a; frame_id++;
      @(negedge clk);
      frame_start = 1'b0;
   endtask

   initial begin
      int a1;
      seed = $urandom;
      repeat (3) @(negedge clk);
      chk("rst_video0", 32'(vd0), 0);
      chk("rst_underflow0", 32'(uf0), 0);
      chk("rst_mem_rd0", 32'(mif[0].mem_rd), 0);
      chk("rst_mem_addr0", mif[0].mem_addr, 0);
      chk("rst_video1", 32'(vd1), 0);
      chk("rst_mem_rd1", 32'(mif[1].mem_rd), 0);
      reset = 1'b1;
      repeat (5) @(negedge clk);
      chk("idle_no_req", 32'(mif[0].mem_rd), 0);

      // Base fill: credit stops at FIFO_DEPTH words.
      start(32'h1000);
      repeat (20) @(negedge clk);
      chk("fill_count", 32'(m_acc), 8);
      chk("fill_last_addr", last_addr0, 32'h101C);
      chk("fill_stop", 32'(mif[0].mem_rd), 0);

      // Unpack order and refill after the first pop.
      pix_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("unpack_byte", 32'(vd0), byte_of(32'h1000, i));
         if (i == 2) chk("no_9th_before_pop", 32'(mif[0].mem_rd), 0);
      end
      pix_req = 1'b0;
      chk("9th_req", 32'(mif[0].mem_rd), 1);
      chk("9th_addr", mif[0].mem_addr, 32'h1020);

      // Randomized phase, including an address wrap and random restarts.
      start(32'hFFFF_FFF8);
      rnd = 1;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         pix_req = ($urandom_range(0, 99) < 35);
         if ($urandom_range(0, 99) == 0) begin
            frame_start = 1'b1; base_addr = $urandom & 32'hFFFF_FFFC; frame_id++;
         end else frame_start = 1'b0;
      end
      @(negedge clk);
      frame_start = 1'b0; pix_req = 1'b0; rnd = 0;

      // Underflow is sticky until the next frame_start.
      hold = 1;
      start(32'h3000);
      repeat (3) @(negedge clk);
      pix_req = 1'b1;
      @(negedge clk);
      pix_req = 1'b0;
      chk("uf_data", 32'(vd0), 0);
      chk("uf_flag", 32'(uf0), 1);
      hold = 0;
      repeat (10) @(negedge clk);
      chk("uf_sticky", 32'(uf0), 1);
      start(32'h3000);
      chk("uf_cleared", 32'(uf0), 0);
      repeat (20) @(negedge clk);

      // Restart with three reads in flight: old data must be dropped.
      hold = 1; rdy_off = 1;
      start(32'h5000);
      rdy_off = 0;
      repeat (3) @(negedge clk);
      rdy_off = 1;
      chk("restart_inflight", 32'(m_acc), 3);
      start(32'h2000);
      rdy_off = 0;
      repeat (2) @(negedge clk);
      hold = 0;
      repeat (25) @(negedge clk);
      chk("restart_reqs", 32'(m_acc), 8);
      pix_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("restart_byte", 32'(vd0), byte_of(32'h2000, i));
      end
      pix_req = 1'b0;

      // Asynchronous reset mid-operation.
      start(32'h1000);
      repeat (6) @(negedge clk);
      pix_req = 1'b1;
      @(negedge clk);
      pix_req = 1'b0;
      chk("pre_reset_byte", 32'(vd0), 32'h11);
      #2 reset = 1'b0;
      #1;
      chk("arst_video", 32'(vd0), 0);
      chk("arst_underflow", 32'(uf0), 0);
      chk("arst_mem_rd", 32'(mif[0].mem_rd), 0);
      chk("arst_mem_addr", mif[0].mem_addr, 0);
      @(negedge clk);
      reset = 1'b1;
      repeat (6) @(negedge clk);
      chk("arst_no_req", 32'(mif[0].mem_rd), 0);

      // Frame end on the 4-word instance.
      a1 = g_mem[1].acc_cnt;
      start(32'h8000);
      repeat (15) @(negedge clk);
      chk("fe_reqs", 32'(g_mem[1].acc_cnt - a1), 4);
      chk("fe_done_no_req", 32'(mif[1].mem_rd), 0);
      pix_req = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         chk("fe_pixel", 32'(vd1), byte_of(32'h8000, i));
         chk("fe_no_uf", 32'(uf1), 0);
      end
      @(negedge clk);
      pix_req = 1'b0;
      chk("fe_17th_data", 32'(vd1), 0);
      chk("fe_17th_uf", 32'(uf1), 1);
      chk("fe_still_done", 32'(mif[1].mem_rd), 0);
      chk("fe_total_reqs", 32'(g_mem[1].acc_cnt - a1), 4);

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
